eth_tx_payload_source: RTL

Parametrised payload generator for the RMII transmit chain. It buffers up to DEPTH words of DATA_WIDTH bits and, on a start request, streams them MSB-first as 2-bit AXI-stream dibits into the MAC-header/bit-order/CRC pipeline. It zero-pads short frames up to a minimum payload length, enforces an inter-frame gap, optionally repeats frames continuously, and counts frames sent. It replaces the fixed 32-bit, button-triggered, single-word source with a reusable block.

---
 rtl/eth_tx_payload_source.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_payload_source.sv
// Buffered payload source for the RMII TX chain: streams words MSB-first
// as dibits, zero-pads to a minimum length, inserts a gap, optionally repeats.
module eth_tx_payload_source #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 8,
  parameter int MIN_PAYLOAD_BYTES = 46,
  parameter int IFG_CYCLES        = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         clr,
  input  logic                         start,
  input  logic                         continuous,
  output logic                         axiov,
  output logic [1:0]                   axiod,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic [31:0]                  frame_count,
  output logic                         overflow
);

  localparam int DPW  = DATA_WIDTH / 2;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIW  = (DPW > 1) ? $clog2(DPW) : 1;
  localparam int PLEN = MIN_PAYLOAD_BYTES * 4;
  localparam int DMAX = DEPTH * DPW;
  localparam int LMAX = (DMAX > PLEN) ? DMAX : PLEN;
  localparam int PW   = $clog2(LMAX + 1);
  localparam int GW   = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    PAD,
    GAP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [CW-1:0]         widx_q, widx_d;
  logic [DIW-1:0]        didx_q, didx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [CW-1:0]         wc_q, wc_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           fc_q, fc_d;
  logic                  rep_q, rep_d;
  logic                  prev_start_q;
  logic                  axiov_q, axiov_d;
  logic [1:0]            axiod_q, axiod_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  start_edge;
  logic                  mem_we;
  logic                  step;
  logic [PW-1:0]         d_len;
  logic [PW-1:0]         frame_len;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DIW-1:0]        dsel;
  logic [1:0]            cur_dibit;

  assign start_edge = start & ~prev_start_q;
  assign d_len      = PW'(wc_q) * PW'(DPW);
  assign frame_len  = (d_len > PW'(PLEN)) ? d_len : PW'(PLEN);
  assign cur_word   = mem_q[AW'(widx_q)];
  assign dsel       = DIW'(DPW - 1) - didx_q;
  assign cur_dibit  = cur_word[{dsel, 1'b0} +: 2];

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    widx_d  = widx_q;
    didx_d  = didx_q;
    gap_d   = gap_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    fc_d    = fc_q;
    rep_d   = rep_q;
    axiov_d = 1'b0;
    axiod_d = 2'b00;
    mem_we  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge && wc_q != '0) begin
          step  = 1'b1;
          rep_d = continuous;
        end else if (clr) begin
          wc_d  = '0;
          ovf_d = 1'b0;
        end else if (wr_en) begin
          if (wc_q < CW'(DEPTH)) begin
            mem_we = 1'b1;
            wc_d   = wc_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      SEND, PAD: step = 1'b1;
      GAP: begin
        if (gap_q == GW'(IFG_CYCLES)) begin
          if (rep_q && continuous) step = 1'b1;
          else state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Cursor is rewound on frame end, so IDLE/GAP starts always begin at word 0
    if (step) begin
      if (pos_q < frame_len) begin
        axiov_d = 1'b1;
        pos_d   = pos_q + PW'(1);
        if (widx_q < wc_q) begin
          axiod_d = cur_dibit;
          state_d = SEND;
          if (didx_q == DIW'(DPW - 1)) begin
            didx_d = '0;
            widx_d = widx_q + CW'(1);
          end else begin
            didx_d = didx_q + DIW'(1);
          end
        end else begin
          state_d = PAD;
        end
      end else begin
        fc_d    = fc_q + 32'd1;
        state_d = GAP;
        gap_d   = GW'(1);
        pos_d   = '0;
        widx_d  = '0;
        didx_d  = '0;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      widx_q       <= '0;
      didx_q       <= '0;
      gap_q        <= '0;
      wc_q         <= '0;
      ovf_q        <= 1'b0;
      fc_q         <= '0;
      rep_q        <= 1'b0;
      prev_start_q <= 1'b1;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      widx_q       <= widx_d;
      didx_q       <= didx_d;
      gap_q        <= gap_d;
      wc_q         <= wc_d;
      ovf_q        <= ovf_d;
      fc_q         <= fc_d;
      rep_q        <= rep_d;
      prev_start_q <= start;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[AW'(wc_q)] <= wr_data;
  end

  assign axiov       = axiov_q;
  assign axiod       = axiod_q;
  assign busy        = busy_q;
  assign word_count  = wc_q;
  assign frame_count = fc_q;
  assign overflow    = ovf_q;

endmodule
